// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RISC-V instruction encoder: immediate-format
// selectors, common opcodes, the buffered entry type and the range helper.
package inst_encoder_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam int ENC_NBW = 32;

    typedef struct packed {
        logic [ENC_NBW-1:0] inst;
        logic [ENC_NBW-1:0] addr;
        logic               err;
    } enc_entry_t;

    // True when bits [31:lsb] of v are all ones or all zeros, i.e. v is a
    // sign-extension of its low lsb+1 bits.
    function automatic logic upper_uniform(input logic [31:0] v, input logic [4:0] lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((v & mask) == mask) || ((v & mask) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle of the instruction encoder; names are from the
// encoder's point of view (i_* into the encoder, o_* out of it).
interface inst_encoder_if #(
    parameter int NBW_INST     = 32,
    parameter int NBW_REGISTER = 32
);
    logic                    i_valid;
    logic                    o_ready;
    logic [1:0]              i_immSrc;
    logic [6:0]              i_opcode;
    logic [4:0]              i_rd;
    logic [2:0]              i_funct3;
    logic [4:0]              i_rs1;
    logic [4:0]              i_rs2;
    logic [NBW_REGISTER-1:0] i_imm;
    logic                    o_valid;
    logic                    i_ready;
    logic [NBW_INST-1:0]     o_inst;
    logic [NBW_REGISTER-1:0] o_addr;
    logic                    o_err;
    logic                    o_err_sticky;

    modport master (
        output i_valid, i_immSrc, i_opcode, i_rd, i_funct3, i_rs1, i_rs2, i_imm, i_ready,
        input  o_ready, o_valid, o_inst, o_addr, o_err, o_err_sticky
    );

    modport slave (
        input  i_valid, i_immSrc, i_opcode, i_rd, i_funct3, i_rs1, i_rs2, i_imm, i_ready,
        output o_ready, o_valid, o_inst, o_addr, o_err, o_err_sticky
    );
endinterface

// File: rtl/inst_encoder_imm_pack.sv
// Scatters a 32-bit signed immediate into its I/S/B instruction bit positions
// and reports whether the value is representable in that format.
module inst_encoder_imm_pack
    import inst_encoder_pkg::*;
(
    input  logic [1:0]  i_immSrc,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_field,
    output logic        o_range_ok,
    output logic        o_has_rd
);

    // Format-dependent scatter and range check; 2'b11 falls back to I.
    always_comb begin
        o_imm_field = {i_imm[11:0], 20'b0};
        o_range_ok  = upper_uniform(i_imm, 5'd11);
        o_has_rd    = 1'b1;
        case (i_immSrc)
            IMM_S: begin
                o_imm_field = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_range_ok  = upper_uniform(i_imm, 5'd11);
                o_has_rd    = 1'b0;
            end
            IMM_B: begin
                o_imm_field = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                o_range_ok  = upper_uniform(i_imm, 5'd12) & ~i_imm[0];
                o_has_rd    = 1'b0;
            end
            default: begin
                o_imm_field = {i_imm[11:0], 20'b0};
                o_range_ok  = upper_uniform(i_imm, 5'd11);
                o_has_rd    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs register fields plus immediate into RISC-V words and streams them,
// with their IMEM byte address, through a 2-entry skid buffer.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                      NBW_INST     = 32,
    parameter int                      NBW_REGISTER = 32,
    parameter logic [NBW_REGISTER-1:0] BASE_ADDR    = {NBW_REGISTER{1'b0}}
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    inst_encoder_if.slave bus
);

    localparam logic [NBW_REGISTER-1:0] ADDR_STEP = {{(NBW_REGISTER-3){1'b0}}, 3'd4};

    enc_entry_t              head_r, skid_r, head_n_s, skid_n_s, new_s;
    logic                    head_valid_r, skid_valid_r, head_valid_n_s, skid_valid_n_s;
    logic                    ready_r, sticky_r;
    logic [NBW_REGISTER-1:0] next_addr_r;
    logic [31:0]             imm_field_s;
    logic                    range_ok_s, has_rd_s, accept_s, xfer_s;

    inst_encoder_imm_pack u_imm_pack (
        .i_immSrc    (bus.i_immSrc),
        .i_imm       (bus.i_imm),
        .o_imm_field (imm_field_s),
        .o_range_ok  (range_ok_s),
        .o_has_rd    (has_rd_s)
    );

    assign accept_s = bus.i_valid & ready_r;
    assign xfer_s   = head_valid_r & bus.i_ready;

    // Word under construction: rd slot for I-type, rs2 slot for S/B-type.
    always_comb begin
        if (has_rd_s) begin
            new_s.inst = imm_field_s | {7'b0, 5'b0, bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
        end else begin
            new_s.inst = imm_field_s | {7'b0, bus.i_rs2, bus.i_rs1, bus.i_funct3, 5'b0, bus.i_opcode};
        end
        new_s.addr = next_addr_r;
        new_s.err  = ~range_ok_s;
    end

    // Skid buffer next state; head is always the oldest entry and drives the outputs.
    always_comb begin
        head_n_s       = head_r;
        skid_n_s       = skid_r;
        head_valid_n_s = head_valid_r;
        skid_valid_n_s = skid_valid_r;
        case ({head_valid_r, skid_valid_r})
            2'b00: begin
                if (accept_s) begin
                    head_n_s       = new_s;
                    head_valid_n_s = 1'b1;
                end else begin
                    head_valid_n_s = 1'b0;
                end
            end
            2'b10: begin
                if (xfer_s && accept_s) begin
                    head_n_s = new_s;
                end else if (xfer_s) begin
                    head_valid_n_s = 1'b0;
                end else if (accept_s) begin
                    skid_n_s       = new_s;
                    skid_valid_n_s = 1'b1;
                end else begin
                    head_valid_n_s = 1'b1;
                end
            end
            2'b11: begin
                // ready_r is low when full, so no accept can coincide here
                if (xfer_s) begin
                    head_n_s       = skid_r;
                    skid_valid_n_s = 1'b0;
                end else begin
                    skid_valid_n_s = 1'b1;
                end
            end
            default: begin
                head_valid_n_s = 1'b0;
                skid_valid_n_s = 1'b0;
            end
        endcase
    end

    // Buffer, address counter and sticky error state; clear wins over any handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_r       <= '{inst: 32'h0000_0000, addr: BASE_ADDR, err: 1'b0};
            skid_r       <= '{inst: 32'h0000_0000, addr: BASE_ADDR, err: 1'b0};
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
            sticky_r     <= 1'b0;
            next_addr_r  <= BASE_ADDR;
        end else if (i_clear) begin
            head_r       <= '{inst: 32'h0000_0000, addr: BASE_ADDR, err: 1'b0};
            skid_r       <= '{inst: 32'h0000_0000, addr: BASE_ADDR, err: 1'b0};
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
            sticky_r     <= 1'b0;
            next_addr_r  <= BASE_ADDR;
        end else begin
            head_r       <= head_n_s;
            skid_r       <= skid_n_s;
            head_valid_r <= head_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            ready_r      <= ~(head_valid_n_s & skid_valid_n_s);
            sticky_r     <= sticky_r | (xfer_s & head_r.err);
            next_addr_r  <= accept_s ? (next_addr_r + ADDR_STEP) : next_addr_r;
        end
    end

    assign bus.o_ready      = ready_r;
    assign bus.o_valid      = head_valid_r;
    assign bus.o_inst       = head_r.inst;
    assign bus.o_addr       = head_r.addr;
    assign bus.o_err        = head_r.err;
    assign bus.o_err_sticky = sticky_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against a format-level
// reference model and scoreboard queue.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    logic clk, rst_n, clear;
    inst_encoder_if #(.NBW_INST(32), .NBW_REGISTER(32)) bus ();

    inst_encoder #(.NBW_INST(32), .NBW_REGISTER(32), .BASE_ADDR(BASE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    logic [31:0] got_addrs[$];
    logic [31:0] exp_addr = BASE;
    logic        exp_sticky = 1'b0;
    logic        mon_en = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] hold_inst, hold_addr, last_inst, last_addr;
    logic        hold_err, last_err;
    logic        rnd_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding computed from the format tables with shifts and masks.
    function automatic logic [31:0] model_word(input logic [1:0] src, input logic [6:0] op,
            input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        w = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        if (src == 2'b01)
            w |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
        else if (src == 2'b10)
            w |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
               | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        else
            w |= ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
        return w;
    endfunction

    function automatic logic model_err(input logic [1:0] src, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (src == 2'b10) return (s < -4096) || (s > 4095) || imm[0];
        return (s < -2048) || (s > 2047);
    endfunction

    // Immediate extender: recovers the immediate from an encoded word.
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    // Scoreboard: checks every transferred word, hold stability and the sticky flag.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en) begin
            chk("sticky", 32'(bus.o_err_sticky), 32'(exp_sticky));
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.o_valid), 32'h1);
                chk("hold_inst", bus.o_inst, hold_inst);
                chk("hold_addr", bus.o_addr, hold_addr);
                chk("hold_err", 32'(bus.o_err), 32'(hold_err));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_xfer", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst", bus.o_inst, e.word);
                    chk("addr", bus.o_addr, e.addr);
                    chk("err", 32'(bus.o_err), 32'(e.err));
                    if (!e.err) chk("roundtrip", ext(bus.o_inst, e.src), e.imm);
                    if (e.err) exp_sticky = 1'b1;
                    last_inst = bus.o_inst;
                    last_addr = bus.o_addr;
                    last_err  = bus.o_err;
                    got_addrs.push_back(bus.o_addr);
                end
            end
            prev_hold = bus.o_valid && !bus.i_ready;
            hold_inst = bus.o_inst;
            hold_addr = bus.o_addr;
            hold_err  = bus.o_err;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Issues one request (entered and left at posedge+1) and logs its expectation on accept.
    task automatic send(input logic [1:0] src, input logic [6:0] op, input logic [4:0] rd,
            input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        bus.i_immSrc = src; bus.i_opcode = op; bus.i_rd = rd; bus.i_funct3 = f3;
        bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm; bus.i_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                e.word = model_word(src, op, rd, f3, rs1, rs2, imm);
                e.addr = exp_addr;
                e.err  = model_err(src, imm);
                e.src  = src;
                e.imm  = imm;
                exp_q.push_back(e);
                exp_addr = exp_addr + 32'd4;
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic clear_pulse();
        mon_en = 1'b0;
        clear = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.i_valid = 1'b0;
        exp_q.delete();
        exp_addr = BASE;
        exp_sticky = 1'b0;
        mon_en = 1'b1;
        chk("clear_valid", 32'(bus.o_valid), 32'h0);
        chk("clear_ready", 32'(bus.o_ready), 32'h1);
        chk("clear_addr", bus.o_addr, BASE);
        chk("clear_sticky", 32'(bus.o_err_sticky), 32'h0);
    endtask

    initial begin
        logic [1:0]  src;
        logic [31:0] imm;
        rst_n = 1'b0; clear = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_immSrc = 2'b00; bus.i_opcode = 7'h00;
        bus.i_rd = 5'd0; bus.i_funct3 = 3'd0; bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd0; bus.i_imm = 32'h0;
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_ready", 32'(bus.o_ready), 32'h1);
        chk("rst_inst", bus.o_inst, 32'h0);
        chk("rst_addr", bus.o_addr, BASE);
        chk("rst_err", 32'(bus.o_err), 32'h0);
        chk("rst_sticky", 32'(bus.o_err_sticky), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        bus.i_ready = 1'b1;

        // Latency: word appears the cycle after its accept.
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 32'hFFFF_FFFF);
        chk("lat_valid", 32'(bus.o_valid), 32'h1);
        drain();
        chk("vec_i", last_inst, 32'hFFF1_0093);
        chk("vec_i_addr", last_addr, BASE);
        chk("vec_i_err", 32'(last_err), 32'h0);
        send(IMM_S, OP_STORE, 5'd0, 3'd2, 5'd2, 5'd5, 32'd8);
        drain();
        chk("vec_s", last_inst, 32'h0051_2423);
        send(IMM_B, OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_F000);
        drain();
        chk("vec_b", last_inst, 32'h8000_0063);

        // Range edges.
        send(IMM_I, OP_IMM, 5'd3, 3'd0, 5'd4, 5'd0, 32'd2048);
        drain();
        chk("rng_i2048", 32'(last_err), 32'h1);
        send(IMM_B, OP_BRANCH, 5'd0, 3'd1, 5'd1, 5'd2, 32'd6);
        drain();
        chk("rng_b6", 32'(last_err), 32'h0);
        send(IMM_B, OP_BRANCH, 5'd0, 3'd1, 5'd1, 5'd2, 32'd3);
        drain();
        chk("rng_b3", 32'(last_err), 32'h1);
        chk("sticky_set", 32'(bus.o_err_sticky), 32'h1);

        // Backpressure: two fill the buffer, two more wait for i_ready.
        clear_pulse();
        got_addrs.delete();
        bus.i_ready = 1'b0;
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'd1);
        send(IMM_S, OP_STORE, 5'd0, 3'd2, 5'd3, 5'd4, 32'd12);
        @(negedge clk);
        chk("bp_ready_low", 32'(bus.o_ready), 32'h0);
        chk("bp_valid", 32'(bus.o_valid), 32'h1);
        @(posedge clk); #1;
        fork
            begin
                send(IMM_B, OP_BRANCH, 5'd0, 3'd4, 5'd5, 5'd6, 32'd16);
                send(IMM_I, OP_LOAD, 5'd7, 3'd2, 5'd8, 5'd0, 32'hFFFF_FFF0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(got_addrs.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_addrs.size(); k++)
            chk("bp_addr", got_addrs[k], BASE + 32'(4 * k));

        // Random traffic with random downstream stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    src = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) imm = $urandom;
                    else if (src == 2'b10) imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
                    else imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                    send(src, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), imm);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.i_ready = 1'b1;
        drain();

        // Clear with buffered words and a same-cycle request.
        bus.i_ready = 1'b0;
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'd5);
        send(IMM_I, OP_IMM, 5'd2, 3'd0, 5'd1, 5'd0, 32'd6);
        clear_pulse();
        send(IMM_S, OP_STORE, 5'd0, 3'd0, 5'd1, 5'd2, 32'd4);
        drain();
        chk("clr_restart_addr", last_addr, BASE);

        // Async reset with two buffered words and sticky set.
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'h1000_0000);
        drain();
        bus.i_ready = 1'b0;
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'd7);
        send(IMM_I, OP_IMM, 5'd1, 3'd0, 5'd1, 5'd0, 32'd8);
        chk("pre_rst_sticky", 32'(bus.o_err_sticky), 32'h1);
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'h0);
        chk("arst_ready", 32'(bus.o_ready), 32'h1);
        chk("arst_sticky", 32'(bus.o_err_sticky), 32'h0);
        chk("arst_addr", bus.o_addr, BASE);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_addr = BASE;
        exp_sticky = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        chk("post_rst_valid", 32'(bus.o_valid), 32'h0);
        bus.i_ready = 1'b1;
        send(IMM_I, OP_IMM, 5'd9, 3'd0, 5'd1, 5'd0, 32'd100);
        drain();
        chk("post_rst_addr", last_addr, BASE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
